spi_master_gen2: RTL and testbench

SPI_MASTER_GEN2 -- requirements
Module: spi_master_gen2

---
 rtl/spi_master_gen2_if.sv | 33 +++
 rtl/spi_master_gen2.sv | 147 ++++++++++++++
 tb/tb_spi_master_gen2.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_gen2_if.sv
// Host-side request/response signals plus the SPI wires of spi_master_gen2.
// The master modport is the DUT view; slave is the view of whatever drives it.
interface spi_master_gen2_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CS = 2,
    parameter int unsigned DIV_W  = 8
);
    localparam int unsigned CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic              start;
    logic [CS_W-1:0]   cs_sel;
    logic              cpol;
    logic              cpha;
    logic [DIV_W-1:0]  clk_div;
    logic [DATA_W-1:0] d_in;
    logic              Miso;
    logic              Mosi;
    logic              Sclk;
    logic [NUM_CS-1:0] Cs;
    logic [DATA_W-1:0] d_rec;
    logic              busy;
    logic              done;

    modport master (
        input  start, cs_sel, cpol, cpha, clk_div, d_in, Miso,
        output Mosi, Sclk, Cs, d_rec, busy, done
    );

    modport slave (
        output start, cs_sel, cpol, cpha, clk_div, d_in, Miso,
        input  Mosi, Sclk, Cs, d_rec, busy, done
    );
endinterface

// File: rtl/spi_master_gen2.sv
// SPI master for all four cpol/cpha modes with a programmable Sclk half-period divider.
// Define SPI_MSB_FIRST_EN to shift MSB first; the default build shifts LSB first.
module spi_master_gen2 #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CS = 2,
    parameter int unsigned DIV_W  = 8
) (
    input logic               clk,
    input logic               rst,
    spi_master_gen2_if.master bus
);
    localparam int unsigned CNT_W = $clog2(2 * DATA_W);

    typedef enum logic [1:0] {StIdle, StLead, StShift, StTrail} state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [DIV_W-1:0]  r_clk_div;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_drec;
    logic [NUM_CS-1:0] r_cs;
    logic              r_cpol;
    logic              r_cpha;
    logic              r_sclk;
    logic              r_mosi;
    logic              r_busy;
    logic              r_done;

    logic              w_sel_ok;
    logic              w_accept;
    logic              w_tick;
    logic              w_last_bit;
    logic              w_leading;
    logic              w_tx_bit;
    logic [DATA_W-1:0] w_tx_shift;
    logic [DATA_W-1:0] w_rx_shift;
    logic              w_din_bit;
    logic [DATA_W-1:0] w_din_shift;

    assign w_sel_ok   = 32'(bus.cs_sel) < NUM_CS;
    assign w_accept   = (r_state == StIdle) && bus.start && w_sel_ok;
    assign w_tick     = (r_state != StIdle) && (r_div_cnt == r_clk_div);
    assign w_last_bit = r_bit_cnt == CNT_W'(2 * DATA_W - 1);
    // Sclk still at its idle level means the coming toggle is a leading edge.
    assign w_leading  = r_sclk == r_cpol;

`ifdef SPI_MSB_FIRST_EN
    assign w_tx_bit    = r_tx[DATA_W-1];
    assign w_tx_shift  = {r_tx[DATA_W-2:0], 1'b0};
    assign w_rx_shift  = {r_rx[DATA_W-2:0], bus.Miso};
    assign w_din_bit   = bus.d_in[DATA_W-1];
    assign w_din_shift = {bus.d_in[DATA_W-2:0], 1'b0};
`else
    assign w_tx_bit    = r_tx[0];
    assign w_tx_shift  = {1'b0, r_tx[DATA_W-1:1]};
    assign w_rx_shift  = {bus.Miso, r_rx[DATA_W-1:1]};
    assign w_din_bit   = bus.d_in[0];
    assign w_din_shift = {1'b0, bus.d_in[DATA_W-1:1]};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_d = StLead;
            StLead:  if (w_tick) w_state_d = StShift;
            StShift: if (w_tick && w_last_bit) w_state_d = StTrail;
            StTrail: if (w_tick) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt <= '0;
            r_clk_div <= '0;
            r_bit_cnt <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_drec    <= '0;
            r_cs      <= '1;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_clk_div <= bus.clk_div;
                r_cpol    <= bus.cpol;
                r_cpha    <= bus.cpha;
                r_cs      <= ~(NUM_CS'(1) << bus.cs_sel);
                r_sclk    <= bus.cpol;
                r_busy    <= 1'b1;
                r_div_cnt <= '0;
                r_bit_cnt <= '0;
                r_rx      <= '0;
                // cpha=0 presents the first bit for the whole lead-in half-period.
                if (!bus.cpha) begin
                    r_mosi <= w_din_bit;
                    r_tx   <= w_din_shift;
                end else begin
                    r_mosi <= 1'b0;
                    r_tx   <= bus.d_in;
                end
            end else if (r_state != StIdle) begin
                r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
                if (w_tick && (r_state == StShift)) begin
                    r_sclk    <= ~r_sclk;
                    r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
                    // Sample edge: leading for cpha=0, trailing for cpha=1.
                    if (w_leading ^ r_cpha) begin
                        r_rx <= w_rx_shift;
                    end else begin
                        r_mosi <= w_tx_bit;
                        r_tx   <= w_tx_shift;
                    end
                end else if (w_tick && (r_state == StTrail)) begin
                    r_cs   <= '1;
                    r_drec <= r_rx;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                    r_mosi <= 1'b0;
                end
            end
        end
    end

    assign bus.Mosi  = r_mosi;
    assign bus.Sclk  = r_sclk;
    assign bus.Cs    = r_cs;
    assign bus.d_rec = r_drec;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
endmodule

// File: tb/tb_spi_master_gen2.sv
// Bench for spi_master_gen2: vector table of full frames, scoreboard on done,
// plus hand sequences for ignored starts, bad selects, back-to-back and reset abort.
module tb_spi_master_gen2;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_master_gen2_if #(.DATA_W(8), .NUM_CS(2), .DIV_W(8)) ifc ();
    spi_master_gen2_if #(.DATA_W(8), .NUM_CS(3), .DIV_W(8)) ifc3 ();

    spi_master_gen2 #(.DATA_W(8), .NUM_CS(2), .DIV_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Three selects give a 2-bit cs_sel, so an out-of-range index can be presented.
    spi_master_gen2 #(.DATA_W(8), .NUM_CS(3), .DIV_W(8)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (ifc3)
    );

    typedef struct packed {
        logic       cpol;
        logic       cpha;
        logic [7:0] div;
        logic [7:0] din;
        logic       loopb;
        logic [7:0] slave;
        logic       sel;
        logic [1:0] exp_cs;
        logic [7:0] exp_drec;
    } vec_t;

    vec_t        tbl [6];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_done = 0;
    logic [15:0] sb_q [$];

    logic       loopback = 1'b1;
    logic       mode_cpha = 1'b0;
    logic [7:0] slv_word = 8'h00;
    logic       slv_miso = 1'b0;
    logic [7:0] slv_sh = 8'h00;
    logic [7:0] slv_rx = 8'h00;
    logic       slv_prev = 1'b0;
    logic       slv_act = 1'b0;
    int         slv_edges = 0;

    assign ifc.Miso  = loopback ? ifc.Mosi : slv_miso;
    assign ifc3.Miso = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic first_bit(input logic [7:0] w);
`ifdef SPI_MSB_FIRST_EN
        return w[7];
`else
        return w[0];
`endif
    endfunction

    function automatic logic [7:0] shift_w(input logic [7:0] w);
`ifdef SPI_MSB_FIRST_EN
        return {w[6:0], 1'b0};
`else
        return {1'b0, w[7:1]};
`endif
    endfunction

    function automatic logic [7:0] cap(input logic [7:0] w, input logic b);
`ifdef SPI_MSB_FIRST_EN
        return {w[6:0], b};
`else
        return {b, w[7:1]};
`endif
    endfunction

    // Slave model: edge-counting, so it follows the frame regardless of cpol.
    initial forever begin
        @(negedge clk);
        if (!slv_act && ifc.Cs != 2'b11) begin
            slv_act   = 1'b1;
            slv_edges = 0;
            slv_rx    = 8'h00;
            if (!mode_cpha) begin
                slv_miso = first_bit(slv_word);
                slv_sh   = shift_w(slv_word);
            end else begin
                slv_sh = slv_word;
            end
        end else if (slv_act && ifc.Cs == 2'b11) begin
            slv_act = 1'b0;
        end else if (slv_act && ifc.Sclk != slv_prev) begin
            slv_edges++;
            if (slv_edges[0] ^ mode_cpha) begin
                slv_rx = cap(slv_rx, ifc.Mosi);
            end else begin
                slv_miso = first_bit(slv_sh);
                slv_sh   = shift_w(slv_sh);
            end
        end
        slv_prev = ifc.Sclk;
    end

    // Scoreboard: each done pops one {d_rec, Mosi word} expectation.
    initial forever begin
        logic [15:0] e;
        @(negedge clk);
        if (ifc.done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(ifc.done), 32'(0));
            end else begin
                e = sb_q.pop_front();
                check("d_rec", 32'(ifc.d_rec), 32'(e[15:8]));
                check("mosi_word", 32'(slv_rx), 32'(e[7:0]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time limit, expected bench completion");
        $fatal(1);
    end

    task automatic drive(input logic cpol, input logic cpha, input logic [7:0] div,
                         input logic [7:0] din, input logic sel);
        ifc.cpol    = cpol;
        ifc.cpha    = cpha;
        ifc.clk_div = div;
        ifc.d_in    = din;
        ifc.cs_sel  = sel;
        ifc.start   = 1'b1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int c = 0;
        while (!ifc.done && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(name, 32'(ifc.done), 32'(1));
    endtask

    task automatic run_frame(input vec_t v, input int disturb_at);
        int   hp, cyc, cs_cnt, cs_bad, tog, last, gap_bad, nd;
        logic prev, got;
        hp = int'(v.div) + 1;
        loopback  = v.loopb;
        slv_word  = v.slave;
        mode_cpha = v.cpha;
        @(negedge clk);
        drive(v.cpol, v.cpha, v.div, v.din, v.sel);
        sb_q.push_back({v.exp_drec, v.din});
        nd = n_done;
        @(negedge clk);
        ifc.start = 1'b0;
        check("busy_rise", 32'(ifc.busy), 32'(1));
        cs_cnt = (ifc.Cs == v.exp_cs) ? 1 : 0;
        cs_bad = 1 - cs_cnt;
        cyc = 0; tog = 0; last = 0; gap_bad = 0; got = 1'b0;
        prev = ifc.Sclk;
        for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge clk);
            cyc++;
            if (cyc == disturb_at) begin
                ifc.start   = 1'b1;
                ifc.d_in    = 8'hFF;
                ifc.cpol    = ~v.cpol;
                ifc.cpha    = ~v.cpha;
                ifc.clk_div = 8'd5;
                ifc.cs_sel  = ~v.sel;
            end else if (cyc == disturb_at + 1) begin
                ifc.start = 1'b0;
            end
            if (ifc.done) begin
                got = 1'b1;
            end else begin
                if (ifc.Cs == v.exp_cs) cs_cnt++;
                else cs_bad++;
                if (ifc.Sclk != prev) begin
                    if (tog > 0 && (cyc - last) != hp) gap_bad++;
                    tog++;
                    last = cyc;
                end
                prev = ifc.Sclk;
            end
        end
        check("done_seen", 32'(got), 32'(1));
        check("cs_low_cycles", 32'(cs_cnt), 32'(18 * hp));
        check("cs_wrong_bits", 32'(cs_bad), 32'(0));
        check("sclk_toggles", 32'(tog), 32'(16));
        check("sclk_half_period", 32'(gap_bad), 32'(0));
        check("sclk_idle_cpol", 32'(ifc.Sclk), 32'(v.cpol));
        check("cs_high_at_done", 32'(ifc.Cs), 32'(2'b11));
        check("busy_low_at_done", 32'(ifc.busy), 32'(0));
        check("mosi_idle", 32'(ifc.Mosi), 32'(0));
        @(negedge clk);
        check("done_one_cycle", 32'(ifc.done), 32'(0));
        check("done_count", 32'(n_done - nd), 32'(1));
        check("no_second_frame", 32'(ifc.busy), 32'(0));
    endtask

    initial begin
        int   nd, hi, c3;
        vec_t dv;
        //           cpol  cpha  div   din    loop  slave  sel   exp_cs exp_drec
        tbl[0] = '{1'b0, 1'b0, 8'd0, 8'hA5, 1'b1, 8'h00, 1'b0, 2'b10, 8'hA5};
        tbl[1] = '{1'b0, 1'b1, 8'd3, 8'h3C, 1'b0, 8'hC3, 1'b0, 2'b10, 8'hC3};
        tbl[2] = '{1'b1, 1'b0, 8'd3, 8'h3C, 1'b0, 8'hC3, 1'b0, 2'b10, 8'hC3};
        tbl[3] = '{1'b1, 1'b1, 8'd3, 8'h3C, 1'b0, 8'hC3, 1'b0, 2'b10, 8'hC3};
        tbl[4] = '{1'b1, 1'b1, 8'd0, 8'h5A, 1'b1, 8'h00, 1'b0, 2'b10, 8'h5A};
        tbl[5] = '{1'b0, 1'b0, 8'd1, 8'h96, 1'b0, 8'h69, 1'b1, 2'b01, 8'h69};

        ifc.start = 1'b0; ifc.cs_sel = 1'b0; ifc.cpol = 1'b0; ifc.cpha = 1'b0;
        ifc.clk_div = 8'd0; ifc.d_in = 8'h00;
        ifc3.start = 1'b0; ifc3.cs_sel = 2'd0; ifc3.cpol = 1'b0; ifc3.cpha = 1'b0;
        ifc3.clk_div = 8'd0; ifc3.d_in = 8'h00;

        #12;
        check("rst_cs", 32'(ifc.Cs), 32'(2'b11));
        check("rst_sclk", 32'(ifc.Sclk), 32'(0));
        check("rst_mosi", 32'(ifc.Mosi), 32'(0));
        check("rst_busy", 32'(ifc.busy), 32'(0));
        check("rst_done", 32'(ifc.done), 32'(0));
        check("rst_d_rec", 32'(ifc.d_rec), 32'(0));
        check("rst_cs3", 32'(ifc3.Cs), 32'(3'b111));
        @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 6; v++) run_frame(tbl[v], -1);

        // Start, d_in and the mode inputs disturbed 5 cycles into a frame.
        dv = '{1'b0, 1'b0, 8'd0, 8'h4B, 1'b1, 8'h00, 1'b0, 2'b10, 8'h4B};
        run_frame(dv, 5);

        // Out-of-range select is ignored; a valid one on the same instance works.
        @(negedge clk);
        ifc3.cs_sel = 2'd3; ifc3.start = 1'b1;
        @(negedge clk);
        ifc3.start = 1'b0;
        repeat (3) @(negedge clk);
        check("badsel_busy", 32'(ifc3.busy), 32'(0));
        check("badsel_cs", 32'(ifc3.Cs), 32'(3'b111));
        check("badsel_done", 32'(ifc3.done), 32'(0));
        ifc3.cs_sel = 2'd2; ifc3.d_in = 8'h77; ifc3.start = 1'b1;
        @(negedge clk);
        ifc3.start = 1'b0;
        check("sel2_busy", 32'(ifc3.busy), 32'(1));
        check("sel2_cs", 32'(ifc3.Cs), 32'(3'b011));
        c3 = 0;
        while (!ifc3.done && c3 < 100) begin
            @(negedge clk);
            c3++;
        end
        check("sel2_done", 32'(ifc3.done), 32'(1));
        check("sel2_d_rec", 32'(ifc3.d_rec), 32'(0));

        // Back-to-back: start held high through the done cycle.
        loopback = 1'b1; mode_cpha = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b0, 8'd0, 8'h01, 1'b0);
        sb_q.push_back({8'h01, 8'h01});
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (4) @(negedge clk);
        ifc.start = 1'b1; ifc.d_in = 8'h80;
        sb_q.push_back({8'h80, 8'h80});
        wait_done("b2b_first_done", 100);
        hi = (ifc.Cs == 2'b11) ? 1 : 0;
        @(negedge clk);
        ifc.start = 1'b0;
        while (ifc.Cs == 2'b11 && hi < 10) begin
            hi++;
            @(negedge clk);
        end
        check("b2b_cs_high_cycles", 32'(hi), 32'(1));
        check("b2b_busy", 32'(ifc.busy), 32'(1));
        wait_done("b2b_second_done", 100);
        @(negedge clk);

        // Reset partway through a cpol=1 frame, then restart.
        loopback = 1'b1; mode_cpha = 1'b0;
        @(negedge clk);
        drive(1'b1, 1'b0, 8'd1, 8'hC6, 1'b0);
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (18) @(negedge clk);
        nd = n_done;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_cs", 32'(ifc.Cs), 32'(2'b11));
        check("abort_sclk", 32'(ifc.Sclk), 32'(0));
        check("abort_busy", 32'(ifc.busy), 32'(0));
        check("abort_d_rec", 32'(ifc.d_rec), 32'(0));
        check("abort_mosi", 32'(ifc.Mosi), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(n_done - nd), 32'(0));
        check("abort_sclk_idle", 32'(ifc.Sclk), 32'(0));
        mode_cpha = 1'b1;
        drive(1'b1, 1'b1, 8'd0, 8'h3C, 1'b0);
        sb_q.push_back({8'h3C, 8'h3C});
        check("restart_sclk_before", 32'(ifc.Sclk), 32'(0));
        @(negedge clk);
        ifc.start = 1'b0;
        check("restart_sclk_cpol", 32'(ifc.Sclk), 32'(1));
        wait_done("restart_done", 100);
        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
